// File: rtl/seq_detector_p.sv
// Serial pattern detector: shifts x into a PATTERN_W-bit window on enabled edges
// and pulses s for one cycle on each match, with a saturating match counter.
module seq_detector_p #(
  parameter int                     PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0]   PATTERN   = 4'b1011,
  parameter bit                     OVERLAP   = 1'b1,
  parameter int                     CNT_W     = 8,
  localparam int                    FILL_W    = $clog2(PATTERN_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic              x,
  output logic              s,
  output logic [CNT_W-1:0]  count,
  output logic              sat,
  output logic [FILL_W-1:0] fill
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [PATTERN_W-1:0] window_q, window_d;
  logic [FILL_W-1:0]    fill_q,   fill_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic                 s_q,      s_d;
  logic                 sat_q,    sat_d;
  logic                 match;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    window_d = window_q;
    fill_d   = fill_q;
    count_d  = count_q;
    s_d      = 1'b0;
    match    = 1'b0;

    if (clear) begin
      window_d = '0;
      fill_d   = '0;
      count_d  = '0;
    end else if (en) begin
      window_d = {window_q[PATTERN_W-2:0], x};
      fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
      // Match is judged on the post-shift window; fill gates out stale pre-reset/clear bits.
      match    = (window_d == PATTERN) && (fill_d == FILL_MAX);
      if (match) begin
        s_d     = 1'b1;
        count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
        if (!OVERLAP) fill_d = '0;
      end
    end

    sat_d = (count_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      s_q      <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      window_q <= window_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      s_q      <= s_d;
      sat_q    <= sat_d;
    end
  end

  assign s     = s_q;
  assign count = count_q;
  assign sat   = sat_q;
  assign fill  = fill_q;

endmodule

// File: tb/tb_seq_detector_p.sv
// Directed, table-driven bench for seq_detector_p covering overlap, non-overlap,
// stall, saturation, clear priority and asynchronous reset.
module tb_seq_detector_p;

  logic clk = 1'b0;
  logic rst_n, clear, en, x;

  logic       s_ov, sat_ov, s_nov, sat_nov, s_sat, sat_sat;
  logic [7:0] cnt_ov, cnt_nov;
  logic [1:0] cnt_sat;
  logic [2:0] fill_ov, fill_nov, fill_sat;

  seq_detector_p u_ov (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .x(x),
    .s(s_ov), .count(cnt_ov), .sat(sat_ov), .fill(fill_ov)
  );

  seq_detector_p #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .x(x),
    .s(s_nov), .count(cnt_nov), .sat(sat_nov), .fill(fill_nov)
  );

  seq_detector_p #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .x(x),
    .s(s_sat), .count(cnt_sat), .sat(sat_sat), .fill(fill_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit clr;
    bit en;
    bit x;
    bit exp_s;
    int exp_cnt;
    int exp_fill;
    bit exp_sat;
  } vec_t;

  typedef enum int { SEL_OV, SEL_NOV, SEL_SAT } sel_e;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input bit c, input bit e, input bit b, input bit es,
                              input int ec, input int ef, input bit esat);
    vec_t v;
    v.clr = c; v.en = e; v.x = b; v.exp_s = es;
    v.exp_cnt = ec; v.exp_fill = ef; v.exp_sat = esat;
    vecs.push_back(v);
  endfunction

  task automatic check_dut(input string tag, input sel_e sel, input bit es,
                           input int ec, input int ef, input bit esat);
    int as, ac, af, asat;
    case (sel)
      SEL_OV:  begin as = int'(s_ov);  ac = int'(cnt_ov);  af = int'(fill_ov);  asat = int'(sat_ov);  end
      SEL_NOV: begin as = int'(s_nov); ac = int'(cnt_nov); af = int'(fill_nov); asat = int'(sat_nov); end
      default: begin as = int'(s_sat); ac = int'(cnt_sat); af = int'(fill_sat); asat = int'(sat_sat); end
    endcase
    check({tag, ".s"},     as,   int'(es));
    check({tag, ".count"}, ac,   ec);
    check({tag, ".fill"},  af,   ef);
    check({tag, ".sat"},   asat, int'(esat));
  endtask

  // Applies the queued vectors one edge each, checks #1 after the edge, then empties the queue.
  task automatic run_vecs(input string name, input sel_e sel);
    foreach (vecs[i]) begin
      clear = vecs[i].clr;
      en    = vecs[i].en;
      x     = vecs[i].x;
      @(posedge clk);
      #1;
      check_dut($sformatf("%s[%0d]", name, i), sel, vecs[i].exp_s,
                vecs[i].exp_cnt, vecs[i].exp_fill, vecs[i].exp_sat);
    end
    vecs.delete();
    clear = 1'b0;
    en    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; en = 1'b1; x = 1'b1;
    #3;
    check_dut("reset_ov",  SEL_OV,  0, 0, 0, 0);
    check_dut("reset_sat", SEL_SAT, 0, 0, 0, 0);
    #9 rst_n = 1'b1;
    en = 1'b0;

    // Overlapping detection of 1011 in 1,0,1,1,0,1,1
    add(1,1,1, 0,0,0,0);
    add(0,1,1, 0,0,1,0); add(0,1,0, 0,0,2,0); add(0,1,1, 0,0,3,0);
    add(0,1,1, 1,1,4,0); add(0,1,0, 0,1,4,0); add(0,1,1, 0,1,4,0);
    add(0,1,1, 1,2,4,0);
    run_vecs("overlap", SEL_OV);

    // Non-overlapping: window restarts after the first match
    add(1,1,1, 0,0,0,0);
    add(0,1,1, 0,0,1,0); add(0,1,0, 0,0,2,0); add(0,1,1, 0,0,3,0);
    add(0,1,1, 1,1,0,0); add(0,1,0, 0,1,1,0); add(0,1,1, 0,1,2,0);
    add(0,1,1, 0,1,3,0);
    run_vecs("no_overlap", SEL_NOV);

    // Stall: en=0 edges hold state and keep s low
    add(1,1,1, 0,0,0,0);
    add(0,1,1, 0,0,1,0); add(0,1,0, 0,0,2,0);
    add(0,0,0, 0,0,2,0); add(0,0,0, 0,0,2,0); add(0,0,0, 0,0,2,0);
    add(0,1,1, 0,0,3,0); add(0,1,1, 1,1,4,0);
    // Clear wins over en on the edge that would complete 1011
    add(0,1,1, 0,1,4,0); add(0,1,0, 0,1,4,0); add(0,1,1, 0,1,4,0);
    add(1,1,1, 0,0,0,0);
    run_vecs("stall_clear", SEL_OV);

    // Saturation with CNT_W=2: count 1,2,3,3 and s still pulses at saturation
    add(1,1,1, 0,0,0,0);
    add(0,1,1, 0,0,1,0); add(0,1,0, 0,0,2,0); add(0,1,1, 0,0,3,0);
    add(0,1,1, 1,1,4,0); add(0,1,0, 0,1,4,0); add(0,1,1, 0,1,4,0);
    add(0,1,1, 1,2,4,0); add(0,1,0, 0,2,4,0); add(0,1,1, 0,2,4,0);
    add(0,1,1, 1,3,4,1); add(0,1,0, 0,3,4,1); add(0,1,1, 0,3,4,1);
    add(0,1,1, 1,3,4,1);
    add(0,0,1, 0,3,4,1);
    add(1,0,0, 0,0,0,0);
    run_vecs("saturate", SEL_SAT);

    // Async reset mid-cycle after a match and a partial 1,0,1
    add(1,1,1, 0,0,0,0);
    add(0,1,1, 0,0,1,0); add(0,1,0, 0,0,2,0); add(0,1,1, 0,0,3,0);
    add(0,1,1, 1,1,4,0); add(0,1,0, 0,1,4,0); add(0,1,1, 0,1,4,0);
    run_vecs("pre_reset", SEL_OV);
    #3 rst_n = 1'b0;
    #1 check_dut("async_reset", SEL_OV, 0, 0, 0, 0);
    en = 1'b1; x = 1'b1;
    @(posedge clk);
    #1 check_dut("held_in_reset", SEL_OV, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    add(0,1,1, 0,0,1,0);
    add(0,1,0, 0,0,2,0);
    run_vecs("post_reset", SEL_OV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/seq_detector_p.md
SEQ_DETECTOR_P -- requirements
Module: seq_detector_p

Interface
REQ-001 The block SHALL have parameter PATTERN_W, default 4, meaning pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter PATTERN, default 4'b1011, meaning target bit sequence; the MSB is the oldest bit received.
REQ-003 The block SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches allowed, 0 = window restarts after a match.
REQ-004 The block SHALL have parameter CNT_W, default 8, meaning match counter width, legal range 1..16.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 clear  input  1  synchronous clear of window, fill, s, count and sat.
REQ-008 en  input  1  sample enable; x is consumed only on edges where en=1.
REQ-009 x  input  1  serial data bit.
REQ-010 s  output  1  registered match pulse.
REQ-011 count  output  CNT_W  number of matches since reset or clear, saturating.
REQ-012 sat  output  1  high while count is at its maximum value, 2^CNT_W-1.
REQ-013 fill  output  clog2(PATTERN_W+1)  number of valid bits in the window, 0..PATTERN_W.

Function
REQ-014 The block SHALL keep a PATTERN_W-bit shift window: on an edge with en=1 and clear=0, window <= {window[PATTERN_W-2:0], x}.
REQ-015 On such an edge, fill SHALL increment by 1, saturating at PATTERN_W.
REQ-016 A match SHALL be evaluated on the post-shift window and fill: new window == PATTERN and new fill == PATTERN_W.
REQ-017 s SHALL be 1 for the cycle following the edge on which a match occurs, and 0 otherwise.
REQ-018 Back-to-back matches SHALL hold s high on consecutive cycles; for example, PATTERN all-ones with OVERLAP=1 gives s=1 on every edge after the window fills.
REQ-019 On a match with OVERLAP=1, window and fill SHALL continue unchanged.
REQ-020 On a match with OVERLAP=0, fill SHALL become 0 on the same edge; the window contents become don't-care because fill gates detection.
REQ-021 On a match, count SHALL increment by 1 unless it is already 2^CNT_W-1, in which case it holds.
REQ-022 sat SHALL equal (count == 2^CNT_W-1) as a registered value, updated on the same edge as count.
REQ-023 An edge with en=0 and clear=0 SHALL hold window, fill, count and sat, and SHALL drive s to 0.
REQ-024 An edge with clear=1 SHALL set window=0, fill=0, s=0, count=0 and sat=0 regardless of en and x; clear has priority over en.
REQ-025 Detection latency SHALL be one edge: the edge that samples the final pattern bit sets s, and s is visible until the next edge.
REQ-026 There SHALL be no combinational path from x to s.
REQ-027 fill SHALL expose the internal fill register directly, with no extra delay.

Reset
REQ-028 When rst_n=0, window, fill, s, count and sat SHALL go to 0 immediately, without waiting for clk.
REQ-029 While rst_n=0, all outputs SHALL hold at 0 and en, clear and x SHALL be ignored.
REQ-030 After rst_n deasserts, operation SHALL start on the first rising edge of clk; a partially received pattern from before reset never produces a match.

Verification
REQ-031 OVERLAP=1 (PATTERN=1011, W=4): x=1,0,1,1,0,1,1 with en=1 -> s=1 after edges 4 and 7; count=2.
REQ-032 OVERLAP=0, same stream -> s=1 after edge 4 only; fill=3 after edge 7; count=1.
REQ-033 Stalled input: x=1,0 with en=1, then 3 edges en=0 (x=0), then x=1,1 with en=1 -> s=0 during the stall, s=1 after the final edge, count=1.
REQ-034 Saturation (CNT_W=2, OVERLAP=1): x=1,0,1,1,0,1,1,0,1,1,0,1,1 -> count goes 1,2,3,3; sat=1 from the third match; s still pulses on the fourth match.
REQ-035 Async reset: rst_n=0 between clock edges after x=1,0,1 -> fill=0 and count=0 immediately; then x=1 -> no match, fill=1.
REQ-036 Clear priority: clear=1 and en=1 on the edge that would complete 1011 -> s=0, count=0, fill=0 after that edge.
